fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: queue entry bundle and pc helpers.
// Also supplies the ROM address width default used across the slice.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

package fetch_pkg;

  localparam int AW_DEF = `ROM_ADDRESS_BITWIDTH;
  localparam int QDEPTH = 2;

  typedef logic [AW_DEF-1:0] pc_t;

  typedef struct packed {
    pc_t         pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic pc_t pc_align(input pc_t a);
    return {a[AW_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {pc, instr}; head is entry 0.
// Ports: clk, rst_n, push/wdata, pop, flush, count, head.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0;
  fetch_entry_t e1;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && !pop_ok: begin
          if (count == 2'd0) e0 <= wdata;
          else               e1 <= wdata;
          count <= count + 2'd1;
        end
        !push && pop_ok: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        push && pop_ok: begin
          if (count == 2'd1) begin
            e0 <= wdata;
          end else begin
            e0 <= e1;
            e1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue rule upstream keeps a full queue from seeing push+pop.
  always @(posedge clk) begin
    if (rst_n && !flush)
      assert (!(push && pop_ok && count == 2'd2));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues pcs to a registered ROM, buffers returns.
// Ports: clk, reset_n, rom_address/rom_data, redirect_*, out_* handshake.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = `ROM_ADDRESS_BITWIDTH,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [AW-1:0] rom_address,
  input  logic [31:0]   rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [31:0]   out_instr
);

  logic [AW-1:0] pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic [1:0]    count;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occ;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign rom_address = pc;
  assign pop         = out_valid && out_ready;

  // Slots that will be occupied next cycle before any new issue.
  assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = !redirect_valid && (occ <= 3'd1);
  assign push  = inflight && !redirect_valid;

  assign wdata.pc    = inflight_pc;
  assign wdata.instr = rom_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[AW-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + AW'(4);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule
